// File: rtl/set_encode.sv
// Serialises one value/strobe command per request into '#', type, code x2, [6 hex], [LF] ASCII bytes.
// First byte is valid the cycle after accept; each byte holds on data_out until ack_out, and requests are refused while busy.
module set_encode #(
  parameter bit ADD_NEWLINE = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_stb,
  output logic        req_ack,
  input  logic        req_type,
  input  logic [7:0]  req_code,
  input  logic [23:0] req_value,
  output logic [7:0]  data_out,
  output logic        stb_out,
  input  logic        ack_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HASH   = 4'd1,
    TYPE   = 4'd2,
    CODE_1 = 4'd3,
    CODE_2 = 4'd4,
    HEX_1  = 4'd5,
    HEX_2  = 4'd6,
    HEX_3  = 4'd7,
    HEX_4  = 4'd8,
    HEX_5  = 4'd9,
    HEX_6  = 4'd10,
    TERM   = 4'd11,
    DONE   = 4'd12,
    ERR    = 4'd13
  } state_t;

  // State that follows the last payload byte of either frame type.
  localparam state_t TAIL = ADD_NEWLINE ? TERM : DONE;

  state_t      state_q, state_d;
  logic        type_q, type_d;
  logic [7:0]  code_q, code_d;
  logic [23:0] value_q, value_d;
  logic [3:0]  nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      type_q  <= 1'b0;
      code_q  <= 8'h00;
      value_q <= 24'h000000;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      code_q  <= code_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    code_d  = code_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (req_stb) begin
          type_d  = req_type;
          code_d  = req_code;
          value_d = req_value;
          state_d = (req_code == 8'h00) ? ERR : HASH;
        end
      end
      HASH:   if (ack_out) state_d = TYPE;
      TYPE:   if (ack_out) state_d = CODE_1;
      CODE_1: if (ack_out) state_d = CODE_2;
      CODE_2: if (ack_out) state_d = type_q ? TAIL : HEX_1;
      HEX_1:  if (ack_out) state_d = HEX_2;
      HEX_2:  if (ack_out) state_d = HEX_3;
      HEX_3:  if (ack_out) state_d = HEX_4;
      HEX_4:  if (ack_out) state_d = HEX_5;
      HEX_5:  if (ack_out) state_d = HEX_6;
      HEX_6:  if (ack_out) state_d = TAIL;
      TERM:   if (ack_out) state_d = DONE;
      DONE:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nib = 4'h0;
    case (state_q)
      HEX_1:   nib = value_q[23:20];
      HEX_2:   nib = value_q[19:16];
      HEX_3:   nib = value_q[15:12];
      HEX_4:   nib = value_q[11:8];
      HEX_5:   nib = value_q[7:4];
      HEX_6:   nib = value_q[3:0];
      default: nib = 4'h0;
    endcase
  end

  // Outputs decode straight from state so reset drops stb_out without waiting for a clock.
  always_comb begin
    data_out = 8'h00;
    stb_out  = 1'b0;
    case (state_q)
      HASH: begin
        data_out = 8'h23;
        stb_out  = 1'b1;
      end
      TYPE: begin
        data_out = type_q ? 8'h3E : 8'h24;
        stb_out  = 1'b1;
      end
      CODE_1, CODE_2: begin
        data_out = code_q;
        stb_out  = 1'b1;
      end
      HEX_1, HEX_2, HEX_3, HEX_4, HEX_5, HEX_6: begin
        data_out = hex_ascii(nib);
        stb_out  = 1'b1;
      end
      TERM: begin
        data_out = 8'h0A;
        stb_out  = 1'b1;
      end
      default: begin
        data_out = 8'h00;
        stb_out  = 1'b0;
      end
    endcase
  end

  assign req_ack = req_stb & (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = (state_q == ERR);

endmodule
